// File: rtl/dds_lut_scheduler.sv
// dds_lut_scheduler: round-robin sharing of one registered-read sine memory between
// NUM_CH phase-accumulator channels. One slot per channel: hold the address for the
// memory latency, then capture the returned sample and advance that channel's phase.
module dds_lut_scheduler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]          cfg_freq,
  input  logic                      phase_sync,
  output logic [8:0]                rom_addr,
  input  logic [9:0]                rom_data,
  output logic [9:0]                sample_out,
  output logic [$clog2(NUM_CH)-1:0] sample_ch,
  output logic                      sample_valid,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned ChW   = $clog2(NUM_CH);
  localparam int unsigned WaitW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [WaitW-1:0] LastWait = WaitW'(ROM_LATENCY - 1);
  localparam logic [ChW-1:0]   LastCh   = ChW'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StHold, StCapture} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [ChW-1:0]     ch_ptr_q, ch_ptr_d, next_ptr;
  logic [8:0]         rom_addr_q, rom_addr_d;
  logic [9:0]         sample_out_q, sample_out_d;
  logic [ChW-1:0]     sample_ch_q, sample_ch_d;
  logic               sample_valid_q, sample_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [ACC_W-1:0]   phase_q [NUM_CH];
  logic [ACC_W-1:0]   phase_d [NUM_CH];
  logic [ACC_W-1:0]   freq_q  [NUM_CH];
  logic [ACC_W-1:0]   freq_d  [NUM_CH];

  // Next-state: slot sequencing, sample capture, phase advance, config and sync.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    ch_ptr_d       = ch_ptr_q;
    rom_addr_d     = rom_addr_q;
    sample_out_d   = sample_out_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    phase_d        = phase_q;
    freq_d         = freq_q;
    next_ptr       = (ch_ptr_q == LastCh) ? '0 : ch_ptr_q + ChW'(1);

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StHold;
          rom_addr_d = phase_q[ch_ptr_q][ACC_W-1 -: 9];
          wait_d     = '0;
        end
      end
      StHold: begin
        wait_d = wait_q + WaitW'(1);
        if (wait_q == LastWait) state_d = StCapture;
      end
      StCapture: begin
        sample_out_d      = rom_data;
        sample_ch_d       = ch_ptr_q;
        sample_valid_d    = 1'b1;
        frame_done_d      = (ch_ptr_q == LastCh);
        // Uses the pre-write freq, so a same-cycle cfg_we lands from the next capture.
        phase_d[ch_ptr_q] = phase_q[ch_ptr_q] + freq_q[ch_ptr_q];
        ch_ptr_d          = next_ptr;
        if (enable) begin
          state_d    = StHold;
          rom_addr_d = phase_q[next_ptr][ACC_W-1 -: 9];
          wait_d     = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_we) freq_d[cfg_ch] = cfg_freq;
    // Sync overrides the capture add; the capture itself is unaffected.
    if (phase_sync) begin
      for (int i = 0; i < NUM_CH; i++) phase_d[i] = '0;
    end
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      wait_q         <= '0;
      ch_ptr_q       <= '0;
      rom_addr_q     <= '0;
      sample_out_q   <= 10'd511;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i] <= '0;
        freq_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      ch_ptr_q       <= ch_ptr_d;
      rom_addr_q     <= rom_addr_d;
      sample_out_q   <= sample_out_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      phase_q        <= phase_d;
      freq_q         <= freq_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dds_lut_scheduler.sv
// tb_dds_lut_scheduler: directed and random stimulus against a sample-level reference
// model (per-channel phase/freq arrays advanced on each delivered sample).
module tb_dds_lut_scheduler;

  localparam int NumCh = 4;
  localparam int AccW  = 24;

  logic            clk;
  logic            reset, enable, cfg_we, phase_sync;
  logic [1:0]      cfg_ch;
  logic [AccW-1:0] cfg_freq;
  logic [8:0]      rom_addr;
  logic [9:0]      rom_data;
  logic [9:0]      sample_out;
  logic [1:0]      sample_ch;
  logic            sample_valid, frame_done, busy;

  int tests = 0;
  int fails = 0;

  dds_lut_scheduler #(.NUM_CH(NumCh), .ACC_W(AccW), .ROM_LATENCY(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_freq    (cfg_freq),
    .phase_sync  (phase_sync),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_out  (sample_out),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Injective stand-in for the sine table.
  function automatic logic [9:0] rom_fn(input logic [8:0] a);
    return {a[0], a} ^ 10'h2A5;
  endfunction

  // Two-cycle registered memory.
  logic [9:0] mem_r1, mem_r2;
  always @(posedge clk) begin
    mem_r1 <= rom_fn(rom_addr);
    mem_r2 <= mem_r1;
  end
  assign rom_data = mem_r2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each delivered sample belongs to the next channel in rotation and
  // shows that channel's phase at slot start; the phase then advances by the freq in force
  // before the edge. A sync zeroes phases, but the slot already addressed shows old phase.
  logic [AccW-1:0] m_phase [NumCh];
  logic [AccW-1:0] m_freq  [NumCh];
  logic [AccW-1:0] pre_phase [NumCh];
  int              m_ptr;
  bit              use_pre, model_on;
  logic            p_reset, p_we, p_sync, p_busy;
  logic [1:0]      p_ch;
  logic [AccW-1:0] p_freq;
  logic [8:0]      p_addr, exp_addr;

  initial model_on = 1'b0;

  always begin
    @(posedge clk);
    p_reset = reset; p_we = cfg_we; p_ch = cfg_ch; p_freq = cfg_freq;
    p_sync = phase_sync; p_busy = busy; p_addr = rom_addr;
    #1;
    if (p_reset) begin
      model_on = 1'b1;
      m_ptr = 0;
      use_pre = 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        m_phase[i] = '0;
        m_freq[i]  = '0;
      end
    end else if (model_on) begin
      check("frame_done", frame_done, sample_valid && (m_ptr == NumCh - 1));
      check("addr_stable", (rom_addr == p_addr) || sample_valid || (!p_busy && busy), 1);
      if (sample_valid) begin
        check("sample_ch", sample_ch, m_ptr);
        exp_addr = use_pre ? pre_phase[m_ptr][AccW-1 -: 9] : m_phase[m_ptr][AccW-1 -: 9];
        check("sample_out", sample_out, rom_fn(exp_addr));
        use_pre = 1'b0;
        m_phase[m_ptr] = m_phase[m_ptr] + m_freq[m_ptr];
        m_ptr = (m_ptr + 1) % NumCh;
      end
      if (p_we) m_freq[p_ch] = p_freq;
      if (p_sync) begin
        pre_phase = m_phase;
        for (int i = 0; i < NumCh; i++) m_phase[i] = '0;
        use_pre = 1'b1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; phase_sync = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_freq(input int ch, input logic [AccW-1:0] f);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_freq = f;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sample_valid && cyc < 40);
    check("valid_timeout", sample_valid, 1);
  endtask

  task automatic wait_ch(input int ch);
    int c, n;
    n = 0;
    do begin
      wait_valid(c);
      n++;
    end while (sample_ch != 2'(ch) && n < 8);
    check("wait_ch", sample_ch, ch);
  endtask

  initial begin
    int cyc, f, k;
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; phase_sync = 1'b0;
    cfg_ch = '0; cfg_freq = '0;

    // Reset values
    do_reset();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_sample_out", sample_out, 511);
    check("rst_sample_ch", sample_ch, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);

    // All freq zero: first sample 4 cycles after enable (idle cycle + slot), then every 3
    enable = 1'b1;
    wait_valid(cyc);
    check("first_latency", cyc, 4);
    check("t1_ch0", sample_ch, 0);
    check("t1_busy", busy, 1);
    for (int i = 1; i < 8; i++) begin
      wait_valid(cyc);
      check("slot_period", cyc, 3);
      check("t1_seq", sample_ch, i % NumCh);
      check("t1_addr0", rom_addr, 0);
      check("t1_frame_done", frame_done, (i % NumCh) == NumCh - 1);
    end

    // ch0 steps one address per frame and wraps after 512 frames
    do_reset();
    write_freq(0, 24'h008000);
    enable = 1'b1;
    f = 0;
    while (f <= 512) begin
      wait_valid(cyc);
      if (sample_ch == 2'd0) begin
        if (f == 1)   check("t2_step1", sample_out, rom_fn(9'd1));
        if (f == 511) check("t2_step511", sample_out, rom_fn(9'd511));
        if (f == 512) check("t2_wrap", sample_out, rom_fn(9'd0));
        f++;
      end
    end

    // ch1 at half-turn per frame alternates 0/256, others stay at 0
    do_reset();
    write_freq(1, 24'h800000);
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      wait_valid(cyc);
      if (sample_ch == 2'd1) begin
        check("t3_ch1", sample_out, rom_fn((k % 2 == 1) ? 9'd256 : 9'd0));
        k++;
      end else begin
        check("t3_other", sample_out, rom_fn(9'd0));
      end
    end

    // cfg_we to ch2 during ch2's capture: old freq used for that add
    do_reset();
    write_freq(2, 24'h400000);
    enable = 1'b1;
    wait_ch(2);
    check("t4_f0", sample_out, rom_fn(9'd0));
    wait_ch(1);
    @(negedge clk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_freq = 24'h800000;
    @(negedge clk);
    cfg_we = 1'b0;
    check("t4_collide_valid", sample_valid, 1);
    check("t4_collide_ch", sample_ch, 2);
    check("t4_f1", sample_out, rom_fn(9'd128));
    wait_ch(2);
    check("t4_old_freq", sample_out, rom_fn(9'd256));
    wait_ch(2);
    check("t4_new_freq", sample_out, rom_fn(9'd0));

    // Enable dropped in ch1's hold: ch1 delivered, then idle, resume at ch2
    do_reset();
    enable = 1'b1;
    wait_ch(0);
    enable = 1'b0;
    wait_valid(cyc);
    check("t5_ch1", sample_ch, 1);
    check("t5_busy_fall", busy, 0);
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (sample_valid || busy) k++;
    end
    check("t5_quiet", k, 0);
    enable = 1'b1;
    wait_valid(cyc);
    check("t5_resume", sample_ch, 2);

    // phase_sync during ch2's capture
    do_reset();
    write_freq(0, 24'h100000);
    write_freq(1, 24'h200000);
    write_freq(2, 24'h400000);
    write_freq(3, 24'h080000);
    enable = 1'b1;
    wait_ch(3);
    wait_ch(3);
    wait_ch(1);
    @(negedge clk);
    @(negedge clk);
    phase_sync = 1'b1;
    @(negedge clk);
    phase_sync = 1'b0;
    check("t6_sync_cap", sample_ch, 2);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc);
      check("t6_sync_zero", sample_out, rom_fn(9'd0));
    end

    // Reset during hold: slot aborted
    wait_valid(cyc);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (sample_valid) k++;
    end
    check("t6_no_valid", k, 0);
    check("t6_rst_out", sample_out, 511);
    check("t6_rst_ch", sample_ch, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", rom_addr, 0);

    // Random config, enable and sync traffic checked by the model
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cfg_we   = ($urandom_range(7) == 0);
      cfg_ch   = 2'($urandom_range(3));
      cfg_freq = 24'($urandom);
      if ($urandom_range(49) == 0) enable = !enable;
      phase_sync = enable && busy && !use_pre && ($urandom_range(39) == 0);
    end
    @(negedge clk);
    cfg_we = 1'b0; phase_sync = 1'b0; enable = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
